gpio_port: RTL and testbench

// Parametrised memory-mapped GPIO port on the picoRV32 native memory bus.

---
 rtl/gpio_port.sv | 198 +++++++++++++++++++
 tb/tb_gpio_port.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped bidirectional GPIO port for the picoRV32 native bus.
// Provides output latch with atomic SET/CLR/TOG, per-pin output enable,
// synchronised input readback and an edge-triggered maskable interrupt.
module gpio_port #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WIDTH       = 8,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             valid,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   input  logic [3:0]       wstrb,
   output logic             ready,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] gpio_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   // Start-up mask lasts SYNC_STAGES+1 cycles after reset release.
   localparam int SU_MAX = SYNC_STAGES + 1;
   localparam int CNT_W  = $clog2(SU_MAX + 1);

   localparam logic [3:0] OFF_OUT = 4'h0;
   localparam logic [3:0] OFF_DIR = 4'h1;
   localparam logic [3:0] OFF_IN  = 4'h2;
   localparam logic [3:0] OFF_SET = 4'h3;
   localparam logic [3:0] OFF_CLR = 4'h4;
   localparam logic [3:0] OFF_TOG = 4'h5;
   localparam logic [3:0] OFF_IE  = 4'h6;
   localparam logic [3:0] OFF_POL = 4'h7;
   localparam logic [3:0] OFF_IP  = 4'h8;

   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_ie;
   logic [WIDTH-1:0] r_pol;
   logic [WIDTH-1:0] r_ip;
   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] r_prev;
   logic [CNT_W-1:0] r_su_cnt;
   logic             r_ready;
   logic [31:0]      r_rdata;
   logic             r_irq;

   logic             w_hit;
   logic             w_accept;
   logic             w_write;
   logic [3:0]       w_offset;
   logic [31:0]      w_mask32;
   logic [31:0]      w_d32;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_d;
   logic [WIDTH-1:0] w_in;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_ev;
   logic             w_ev_en;
   logic [WIDTH-1:0] w_ip_clr;
   logic [WIDTH-1:0] w_out_nxt;
   logic [WIDTH-1:0] w_dir_nxt;
   logic [WIDTH-1:0] w_ie_nxt;
   logic [WIDTH-1:0] w_pol_nxt;
   logic [31:0]      w_rd_val;
   logic             w_unused_bits;

   // Bus decode: a transfer is accepted only when no completion is pending.
   assign w_hit    = (addr[31:6] == BASE_ADDR[31:6]);
   assign w_accept = valid & w_hit & ~r_ready;
   assign w_write  = w_accept & (wstrb != 4'b0000);
   assign w_offset = addr[5:2];
   assign w_mask32 = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
   assign w_d32    = wdata & w_mask32;
   assign w_mask   = w_mask32[WIDTH-1:0];
   assign w_d      = w_d32[WIDTH-1:0];

   // Byte address bits and data bits above WIDTH carry no information here.
   assign w_unused_bits = &{1'b0, addr[1:0], w_d32, w_mask32};

   // Edge detection on the synchronised pins, suppressed during start-up.
   assign w_in    = r_sync[SYNC_STAGES-1];
   assign w_rise  = w_in & ~r_prev;
   assign w_fall  = ~w_in & r_prev;
   assign w_ev_en = (r_su_cnt == CNT_W'(SU_MAX));
   assign w_ev    = w_ev_en ? ((r_pol & w_fall) | (~r_pol & w_rise)) : {WIDTH{1'b0}};

   // Next-state of the writable registers from the decoded bus write.
   always_comb begin
      w_out_nxt = r_out;
      w_dir_nxt = r_dir;
      w_ie_nxt  = r_ie;
      w_pol_nxt = r_pol;
      w_ip_clr  = {WIDTH{1'b0}};
      if (w_write) begin
         case (w_offset)
            OFF_OUT: w_out_nxt = (r_out & ~w_mask) | w_d;
            OFF_DIR: w_dir_nxt = (r_dir & ~w_mask) | w_d;
            OFF_SET: w_out_nxt = r_out | w_d;
            OFF_CLR: w_out_nxt = r_out & ~w_d;
            OFF_TOG: w_out_nxt = r_out ^ w_d;
            OFF_IE:  w_ie_nxt  = (r_ie & ~w_mask) | w_d;
            OFF_POL: w_pol_nxt = (r_pol & ~w_mask) | w_d;
            OFF_IP:  w_ip_clr  = w_d;
            default: w_ip_clr  = {WIDTH{1'b0}};
         endcase
      end else begin
         w_ip_clr = {WIDTH{1'b0}};
      end
   end

   // Read multiplexer; write-only and reserved offsets return zero.
   always_comb begin
      w_rd_val = 32'h0000_0000;
      case (w_offset)
         OFF_OUT: w_rd_val[WIDTH-1:0] = r_out;
         OFF_DIR: w_rd_val[WIDTH-1:0] = r_dir;
         OFF_IN:  w_rd_val[WIDTH-1:0] = w_in;
         OFF_IE:  w_rd_val[WIDTH-1:0] = r_ie;
         OFF_POL: w_rd_val[WIDTH-1:0] = r_pol;
         OFF_IP:  w_rd_val[WIDTH-1:0] = r_ip;
         default: w_rd_val = 32'h0000_0000;
      endcase
   end

   // Control/status registers; a new event outranks a same-cycle W1C.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_out <= {WIDTH{1'b0}};
         r_dir <= {WIDTH{1'b0}};
         r_ie  <= {WIDTH{1'b0}};
         r_pol <= {WIDTH{1'b0}};
         r_ip  <= {WIDTH{1'b0}};
      end else begin
         r_out <= w_out_nxt;
         r_dir <= w_dir_nxt;
         r_ie  <= w_ie_nxt;
         r_pol <= w_pol_nxt;
         r_ip  <= (r_ip & ~w_ip_clr) | w_ev;
      end
   end

   // Input synchroniser chain and previous-sample register for edge detect.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= {WIDTH{1'b0}};
         end
         r_prev <= {WIDTH{1'b0}};
      end else begin
         r_sync[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_prev <= w_in;
      end
   end

   // Start-up counter saturates once the synchroniser holds real pin data.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_su_cnt <= {CNT_W{1'b0}};
      end else if (r_su_cnt != CNT_W'(SU_MAX)) begin
         r_su_cnt <= r_su_cnt + CNT_W'(1);
      end else begin
         r_su_cnt <= r_su_cnt;
      end
   end

   // Bus response: one-cycle ready pulse, rdata only meaningful alongside it.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_ready <= 1'b0;
         r_rdata <= 32'h0000_0000;
      end else begin
         r_ready <= w_accept;
         r_rdata <= (w_accept && (wstrb == 4'b0000)) ? w_rd_val : 32'h0000_0000;
      end
   end

   // Interrupt request registered from the current pending/enable state.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_ip & r_ie);
      end
   end

   assign ready   = r_ready;
   assign rdata   = r_rdata;
   assign gpio_o  = r_out;
   assign gpio_oe = r_dir;
   assign irq     = r_irq;

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: scenario-based bench for gpio_port (WIDTH=32, two sync stages).
// Expected read data is queued before each transfer and compared on completion.
module tb_gpio_port;

   localparam logic [31:0] BASE = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        resetn;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;
   logic [31:0] gpio_i;
   logic [31:0] gpio_o;
   logic [31:0] gpio_oe;
   logic        irq;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;
   logic [31:0] rd;
   bit          ok;

   always #5 clk = ~clk;

   gpio_port #(.BASE_ADDR(BASE), .WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .wdata(wdata),
      .wstrb(wstrb), .ready(ready), .rdata(rdata), .gpio_i(gpio_i),
      .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
   );

   // One bus transfer; an expired ready bound is itself a failed comparison.
   task automatic bus_xfer(input logic [5:0] off, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rv, output bit got);
      addr  = BASE | {26'd0, off};
      wdata = d;
      wstrb = s;
      valid = 1'b1;
      got   = 1'b0;
      rv    = 32'h0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ready) begin
            rv  = rdata;
            got = 1'b1;
            break;
         end
      end
      valid = 1'b0;
      wstrb = 4'h0;
      wdata = 32'h0;
      n_checks++;
      if (!got) begin
         n_errors++;
         $display("FAIL bus_timeout: offset %h no ready within 8 cycles, expected ready=1", off);
      end
   endtask

   task automatic do_reset(input logic [31:0] pins);
      gpio_i = pins;
      valid  = 1'b0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(32'h0);
      n_checks++;
      if ({ready, irq, rdata, gpio_o, gpio_oe} !== 98'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: ready=%b irq=%b rdata=%h o=%h oe=%h, expected all 0",
                  ready, irq, rdata, gpio_o, gpio_oe);
      end
      for (int r = 0; r < 10; r++) begin
         exp_q.push_back(32'h0);
         bus_xfer(6'(r * 4), 32'h0, 4'h0, rd, ok);
         exp_v = exp_q.pop_front();
         n_checks++;
         if (rd !== exp_v) begin
            n_errors++;
            $display("FAIL reset_read: offset %h got %h expected %h", r * 4, rd, exp_v);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (ready !== 1'b0 || rdata !== 32'h0) begin
         n_errors++;
         $display("FAIL ready_pulse: ready=%b rdata=%h one cycle later, expected 0/0", ready, rdata);
      end
   endtask

   task automatic test_set_clr_tog();
      bus_xfer(6'h00, 32'h0000_00A5, 4'hF, rd, ok);
      bus_xfer(6'h0C, 32'h0000_000A, 4'hF, rd, ok);
      bus_xfer(6'h10, 32'h0000_0080, 4'hF, rd, ok);
      bus_xfer(6'h14, 32'h0000_00FF, 4'hF, rd, ok);
      n_checks++;
      if (gpio_o !== 32'h0000_00D0) begin
         n_errors++;
         $display("FAIL gpio_o_atomic: got %h expected %h", gpio_o, 32'h0000_00D0);
      end
      exp_q.push_back(32'h0000_00D0);
      bus_xfer(6'h00, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) begin
         n_errors++;
         $display("FAIL out_readback: got %h expected %h", rd, exp_v);
      end
      exp_q.push_back(32'h0);
      bus_xfer(6'h14, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) begin
         n_errors++;
         $display("FAIL tog_reads_zero: got %h expected %h", rd, exp_v);
      end
      bus_xfer(6'h04, 32'h0000_000F, 4'hF, rd, ok);
      n_checks++;
      if (gpio_oe !== 32'h0000_000F) begin
         n_errors++;
         $display("FAIL gpio_oe: got %h expected %h", gpio_oe, 32'h0000_000F);
      end
   endtask

   task automatic test_byte_strobe();
      bus_xfer(6'h00, 32'h0, 4'hF, rd, ok);
      bus_xfer(6'h00, 32'h1234_5678, 4'b0001, rd, ok);
      exp_q.push_back(32'h0000_0078);
      bus_xfer(6'h00, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) begin
         n_errors++;
         $display("FAIL strobe_b0: got %h expected %h", rd, exp_v);
      end
      bus_xfer(6'h00, 32'hAABB_CCDD, 4'b1100, rd, ok);
      exp_q.push_back(32'hAABB_0078);
      bus_xfer(6'h00, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) begin
         n_errors++;
         $display("FAIL strobe_hi: got %h expected %h", rd, exp_v);
      end
      // Address outside the window: no ready, no state change.
      addr  = 32'h0000_0000;
      wdata = 32'hFFFF_FFFF;
      wstrb = 4'hF;
      valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL nohit_ready: cycle %0d ready=%b expected 0", i, ready);
         end
      end
      valid = 1'b0;
      n_checks++;
      if (gpio_o !== 32'hAABB_0078) begin
         n_errors++;
         $display("FAIL nohit_state: gpio_o=%h expected %h", gpio_o, 32'hAABB_0078);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_out;
      exp_out = 32'hAABB_0078;
      for (int run = 3; run >= 2; run--) begin
         addr  = BASE | 32'h14;
         wdata = 32'h0000_0001;
         wstrb = 4'hF;
         valid = 1'b1;
         for (int c = 0; c < run; c++) begin
            exp_q.push_back((c % 2 == 0) ? 32'd1 : 32'd0);
         end
         for (int c = 0; c < run; c++) begin
            @(posedge clk); #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({31'd0, ready} !== exp_v) begin
               n_errors++;
               $display("FAIL b2b_ready: run %0d cycle %0d ready=%b expected %0d", run, c, ready, exp_v);
            end
         end
         valid = 1'b0;
         wstrb = 4'h0;
         @(posedge clk); #1;
         if (run == 2) exp_out = exp_out ^ 32'h1;
         n_checks++;
         if (gpio_o !== exp_out) begin
            n_errors++;
            $display("FAIL b2b_out: run %0d gpio_o=%h expected %h", run, gpio_o, exp_out);
         end
      end
   endtask

   task automatic test_irq();
      do_reset(32'h0000_0001);
      repeat (8) @(posedge clk);
      #1;
      exp_q.push_back(32'h0);
      bus_xfer(6'h20, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v || irq !== 1'b0) begin
         n_errors++;
         $display("FAIL startup_mask: IP=%h irq=%b expected %h/0", rd, irq, exp_v);
      end
      bus_xfer(6'h18, 32'h0000_0003, 4'hF, rd, ok);
      gpio_i = 32'h0000_0003;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL irq_early: irq=%b expected 0 at edge k+2", irq);
      end
      @(posedge clk); #1;
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++;
         $display("FAIL irq_rise: irq=%b expected 1 at edge k+3", irq);
      end
      exp_q.push_back(32'h0000_0002);
      exp_q.push_back(32'h0000_0003);
      bus_xfer(6'h20, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) begin
         n_errors++;
         $display("FAIL ip_rise: got %h expected %h", rd, exp_v);
      end
      bus_xfer(6'h08, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) begin
         n_errors++;
         $display("FAIL in_read: got %h expected %h", rd, exp_v);
      end
      bus_xfer(6'h20, 32'h0000_0002, 4'hF, rd, ok);
      exp_q.push_back(32'h0);
      bus_xfer(6'h20, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v || irq !== 1'b0) begin
         n_errors++;
         $display("FAIL ip_w1c: IP=%h irq=%b expected %h/0", rd, irq, exp_v);
      end
   endtask

   task automatic test_w1c_race();
      bus_xfer(6'h1C, 32'h0000_0001, 4'hF, rd, ok);
      gpio_i = 32'h0000_0002;
      repeat (2) @(posedge clk);
      #1;
      bus_xfer(6'h20, 32'h0000_0001, 4'hF, rd, ok);
      exp_q.push_back(32'h0000_0001);
      bus_xfer(6'h20, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v || irq !== 1'b1) begin
         n_errors++;
         $display("FAIL event_beats_w1c: IP=%h irq=%b expected %h/1", rd, irq, exp_v);
      end
      bus_xfer(6'h20, 32'h0000_0001, 4'hF, rd, ok);
      exp_q.push_back(32'h0);
      bus_xfer(6'h20, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v) begin
         n_errors++;
         $display("FAIL w1c_quiet: got %h expected %h", rd, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      addr   = BASE;
      wdata  = 32'h0000_0055;
      wstrb  = 4'hF;
      valid  = 1'b1;
      resetn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_ready: cycle %0d ready=%b expected 0", i, ready);
         end
      end
      valid  = 1'b0;
      wstrb  = 4'h0;
      resetn = 1'b1;
      exp_q.push_back(32'h0);
      bus_xfer(6'h00, 32'h0, 4'h0, rd, ok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (rd !== exp_v || gpio_o !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_mid_out: OUT=%h gpio_o=%h expected %h", rd, gpio_o, exp_v);
      end
   endtask

   initial begin
      resetn = 1'b0;
      valid  = 1'b0;
      addr   = 32'h0;
      wdata  = 32'h0;
      wstrb  = 4'h0;
      gpio_i = 32'h0;
      test_reset();
      test_set_clr_tog();
      test_byte_strobe();
      test_back_to_back();
      test_irq();
      test_w1c_race();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
